instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 21 ++
 rtl/instr_fetch_pc_next.sv | 19 +
 rtl/instr_fetch.sv | 103 ++++++++++
 tb/tb_instr_fetch.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding, the canonical NOP word and the datapath widths.
package instr_fetch_pkg;

  localparam int XLEN     = 32;
  localparam int OPCODE_W = 7;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-PC arithmetic for the fetch stage: sequential increment and redirect mux.
// Purely combinational; the redirect target is forced onto a word boundary here.
module instr_fetch_pc_next
  import instr_fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic            target_misaligned
);

  // Natural 32-bit overflow gives the required wrap from 0xFFFF_FFFC to 0.
  assign pc_plus4          = pc + 32'd4;
  assign next_pc           = pc_src ? word_align(pc_target) : pc_plus4;
  assign target_misaligned = pc_src && (pc_target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch: FETCH issues a request, WAIT takes the
// response, HOLD presents the instruction until the consumer advances (stall low).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                PCSrc,
  input  logic [XLEN-1:0]     PCTarget,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_rvalid,
  input  logic [XLEN-1:0]     imem_rdata,
  output logic [XLEN-1:0]     PC,
  output logic [XLEN-1:0]     PCPlus4,
  output logic [XLEN-1:0]     Instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic                instr_valid,
  output logic                misalign_err
);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] next_pc;
  logic            misalign_q;
  logic            run_q;
  logic            target_misaligned;
  logic            advance;
  logic            capture;

  // run_q keeps the first request out of the reset cycle itself.
  assign advance = (state == HOLD) && !stall;
  assign capture = (state == WAIT) && imem_rvalid;

  instr_fetch_pc_next pc_next (
    .pc                (pc_q),
    .pc_src            (PCSrc),
    .pc_target         (PCTarget),
    .pc_plus4          (PCPlus4),
    .next_pc           (next_pc),
    .target_misaligned (target_misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (run_q)       state_next = WAIT;
      WAIT:    if (imem_rvalid) state_next = HOLD;
      HOLD:    if (!stall)      state_next = FETCH;
      default:                  state_next = FETCH;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      FETCH:   imem_req    = run_q;
      HOLD:    instr_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      pc_q       <= word_align(RESET_PC);
      instr_q    <= NOP_INSTR;
      misalign_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (capture) begin
        instr_q <= imem_rdata;
      end
      if (advance) begin
        pc_q <= next_pc;
        if (target_misaligned) begin
          misalign_q <= 1'b1;
        end
      end
    end
  end

  assign PC           = pc_q;
  assign imem_addr    = pc_q;
  assign Instr        = instr_valid ? instr_q : NOP_INSTR;
  assign opcode       = Instr[OPCODE_W-1:0];
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a memory responder pushes expected {PC, Instr} pairs as
// it returns data, and a monitor pops them when instr_valid rises.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] Instr;
  logic [6:0]  opcode;
  logic        instr_valid;
  logic        misalign_err;

  logic        auto_rvalid;
  logic [31:0] auto_rdata;
  logic        man_rvalid;
  logic [31:0] man_rdata;
  logic        resp_en;
  int          lat;
  logic        ovr_en;
  logic [31:0] ovr_data;
  logic        mon_en;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign imem_rvalid = auto_rvalid | man_rvalid;
  assign imem_rdata  = auto_rvalid ? auto_rdata : man_rdata;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .PCSrc        (PCSrc),
    .PCTarget     (PCTarget),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .Instr        (Instr),
    .opcode       (opcode),
    .instr_valid  (instr_valid),
    .misalign_err (misalign_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr_en) return ovr_data;
    return {a[24:0], 7'h33};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Memory model: answers a request lat cycles later.
  initial begin
    int          cnt;
    logic [31:0] addr_l;
    cnt = 0;
    addr_l = '0;
    auto_rvalid = 1'b0;
    auto_rdata = '0;
    forever begin
      tick();
      auto_rvalid = 1'b0;
      if (rst_n !== 1'b1) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            auto_rvalid = 1'b1;
            auto_rdata = mem_word(addr_l);
            exp_q.push_back('{pc: addr_l, instr: auto_rdata});
          end
        end
        if (imem_req === 1'b1 && resp_en) begin
          cnt = lat;
          addr_l = imem_addr;
        end
      end
    end
  end

  // Scoreboard pop plus per-cycle invariants.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        if (instr_valid === 1'b1 && prev_v !== 1'b1) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_empty: instr_valid rose with no expected entry (PC=%h Instr=%h)", PC, Instr);
          end else begin
            e = exp_q.pop_front();
            if (PC !== e.pc || Instr !== e.instr) begin
              n_err++;
              $display("FAIL sb_entry: got PC=%h Instr=%h want PC=%h Instr=%h", PC, Instr, e.pc, e.instr);
            end
          end
        end
        n_checks++;
        if (instr_valid !== 1'b1 && (Instr !== NOP_INSTR || opcode !== 7'h13)) begin
          n_err++;
          $display("FAIL nop_when_invalid: got Instr=%h opcode=%h want %h", Instr, opcode, NOP_INSTR);
        end
        n_checks++;
        if (imem_req === 1'b1 && (instr_valid !== 1'b0 || imem_addr[1:0] !== 2'b00)) begin
          n_err++;
          $display("FAIL req_invariant: got valid=%b addr=%h want valid=0 aligned", instr_valid, imem_addr);
        end
      end
      prev_v = instr_valid;
    end
  end

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ctrl: got req=%b valid=%b mis=%b want 0 0 0", imem_req, instr_valid, misalign_err);
    end
    n_checks++;
    if (PC !== 32'h0 || Instr !== NOP_INSTR || opcode !== 7'h13) begin
      n_err++;
      $display("FAIL rst_data: got PC=%h Instr=%h opcode=%h want 0 %h 13", PC, Instr, opcode, NOP_INSTR);
    end
    exp_q.delete();
    mon_en = 1'b1;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL first_req: got req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
    tick();
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL cycle2_wait: got req=%b valid=%b want 0 0", imem_req, instr_valid);
    end
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || PC !== 32'h0 || PCPlus4 !== 32'h4) begin
      n_err++;
      $display("FAIL cycle3_valid: got valid=%b PC=%h PCPlus4=%h want 1 0 4", instr_valid, PC, PCPlus4);
    end
    for (int k = 1; k <= 2; k++) begin
      wait_valid(ok);
      n_checks++;
      if (!ok || PC !== 32'(4 * k) || PCPlus4 !== 32'(4 * k + 4)) begin
        n_err++;
        $display("FAIL seq_pc%0d: got ok=%b PC=%h PCPlus4=%h want PC=%h", k, ok, PC, PCPlus4, 32'(4 * k));
      end
    end
  endtask

  task automatic test_latency();
    logic [31:0] p;
    stall = 1'b1;
    p = PC;
    lat = 5;
    ovr_en = 1'b1;
    ovr_data = 32'h0050_0093;
    stall = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== p + 32'd4) begin
      n_err++;
      $display("FAIL lat_req: got req=%b addr=%h want 1 %h", imem_req, imem_addr, p + 32'd4);
    end
    stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        n_err++;
        $display("FAIL lat_wait%0d: got req=%b valid=%b want 0 0", i, imem_req, instr_valid);
      end
    end
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || Instr !== 32'h0050_0093 || opcode !== 7'b0010011) begin
      n_err++;
      $display("FAIL lat_capture: got valid=%b Instr=%h opcode=%b want 1 00500093 0010011", instr_valid, Instr, opcode);
    end
    ovr_en = 1'b0;
    lat = 1;
  endtask

  task automatic test_stall();
    logic [31:0] p;
    logic [31:0] ins;
    bit ok;
    stall = 1'b1;
    p = PC;
    ins = Instr;
    for (int i = 0; i < 4; i++) begin
      PCSrc = (i < 2);
      PCTarget = 32'h40;
      tick();
      n_checks++;
      if (PC !== p || Instr !== ins || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold%0d: got PC=%h Instr=%h valid=%b req=%b want %h %h 1 0", i, PC, Instr, instr_valid, imem_req, p, ins);
      end
    end
    PCSrc = 1'b0;
    PCTarget = 32'h0;
    stall = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== p + 32'd4) begin
      n_err++;
      $display("FAIL stall_release: got req=%b addr=%h want 1 %h", imem_req, imem_addr, p + 32'd4);
    end
    stall = 1'b1;
    wait_valid(ok);
    n_checks++;
    if (!ok || PC !== p + 32'd4) begin
      n_err++;
      $display("FAIL stall_next_pc: got ok=%b PC=%h want %h", ok, PC, p + 32'd4);
    end
  endtask

  task automatic test_misalign();
    bit ok;
    stall = 1'b1;
    PCSrc = 1'b1;
    PCTarget = 32'h102;
    stall = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || misalign_err !== 1'b1) begin
      n_err++;
      $display("FAIL mis_redirect: got req=%b addr=%h mis=%b want 1 00000100 1", imem_req, imem_addr, misalign_err);
    end
    PCSrc = 1'b0;
    PCTarget = 32'h0;
    wait_valid(ok);
    n_checks++;
    if (!ok || PC !== 32'h100) begin
      n_err++;
      $display("FAIL mis_pc: got ok=%b PC=%h want 00000100", ok, PC);
    end
    wait_valid(ok);
    n_checks++;
    if (!ok || PC !== 32'h104 || misalign_err !== 1'b1) begin
      n_err++;
      $display("FAIL mis_sticky: got ok=%b PC=%h mis=%b want 00000104 1", ok, PC, misalign_err);
    end
    stall = 1'b1;
  endtask

  task automatic test_spurious();
    logic [31:0] p;
    logic [31:0] ins;
    stall = 1'b1;
    p = PC;
    ins = Instr;
    man_rdata = 32'hDEAD_BEEF;
    man_rvalid = 1'b1;
    tick();
    man_rvalid = 1'b0;
    tick();
    n_checks++;
    if (Instr !== ins || PC !== p || instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL spurious: got Instr=%h PC=%h valid=%b want %h %h 1", Instr, PC, instr_valid, ins, p);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    stall = 1'b1;
    PCSrc = 1'b1;
    PCTarget = 32'hFFFF_FFFC;
    stall = 1'b0;
    tick();
    PCSrc = 1'b0;
    PCTarget = 32'h0;
    stall = 1'b1;
    wait_valid(ok);
    n_checks++;
    if (!ok || PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_top: got ok=%b PC=%h PCPlus4=%h want fffffffc 00000000", ok, PC, PCPlus4);
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_req: got req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
    stall = 1'b1;
    wait_valid(ok);
    n_checks++;
    if (!ok || PC !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_pc: got ok=%b PC=%h want 00000000", ok, PC);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] w;
    stall = 1'b1;
    resp_en = 1'b0;
    stall = 1'b0;
    tick();
    tick();
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rw_in_wait: got req=%b valid=%b want 0 0", imem_req, instr_valid);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || PC !== 32'h0 || misalign_err !== 1'b0) begin
      n_err++;
      $display("FAIL rw_reset: got req=%b valid=%b PC=%h mis=%b want 0 0 0 0", imem_req, instr_valid, PC, misalign_err);
    end
    exp_q.delete();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL rw_refetch: got req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
    man_rdata = 32'hDEAD_BEEF;
    man_rvalid = 1'b1;
    tick();
    man_rvalid = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL rw_late_ignored: got valid=%b req=%b want 0 0", instr_valid, imem_req);
    end
    w = mem_word(32'h0);
    exp_q.push_back('{pc: 32'h0, instr: w});
    man_rdata = w;
    man_rvalid = 1'b1;
    tick();
    man_rvalid = 1'b0;
    stall = 1'b1;
    n_checks++;
    if (instr_valid !== 1'b1 || Instr !== w || PC !== 32'h0) begin
      n_err++;
      $display("FAIL rw_fresh: got valid=%b Instr=%h PC=%h want 1 %h 0", instr_valid, Instr, PC, w);
    end
    resp_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    PCSrc = 1'b0;
    PCTarget = '0;
    man_rvalid = 1'b0;
    man_rdata = '0;
    resp_en = 1'b1;
    lat = 1;
    ovr_en = 1'b0;
    ovr_data = '0;
    mon_en = 1'b0;
    test_reset();
    test_latency();
    test_stall();
    test_misalign();
    test_spurious();
    test_wrap();
    test_reset_in_wait();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
